// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter that merges ALU and load results onto the register file write port.
// Define WB_PERF_EN to add the saturating stall_cnt output.
module regfile_wb_arbiter #(
  parameter int AW    = 5,
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  logic [AW-1:0] alu_addr,
  input  logic [DW-1:0] alu_data,
  input  logic          mem_valid,
  output logic          mem_ready,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_data,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          busy
`ifdef WB_PERF_EN
  ,
  output logic [31:0]   stall_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic          hold_valid_q, hold_valid_d;
  logic [AW-1:0] hold_addr_q, hold_addr_d;
  logic [DW-1:0] hold_data_q, hold_data_d;

  logic [AW-1:0] fifo_addr_q [DEPTH];
  logic [DW-1:0] fifo_data_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // rr_last: 0 = ALU granted last, 1 = load granted last
  logic          rr_last_q, rr_last_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;

  logic fifo_ne, both, alu_grant, mem_grant;
  logic alu_push, mem_push;

  // Round-robin grant between the hold register and the FIFO head
  always_comb begin
    fifo_ne   = (count_q != '0);
    both      = hold_valid_q & fifo_ne;
    alu_grant = hold_valid_q & (~fifo_ne | rr_last_q);
    mem_grant = fifo_ne & (~hold_valid_q | ~rr_last_q);
    alu_ready = ~hold_valid_q | alu_grant;
    mem_ready = (count_q < CW'(DEPTH));
    alu_push  = alu_valid & alu_ready;
    mem_push  = mem_valid & mem_ready;
  end

  // Next state for buffers, pointers, arbiter and the write port
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_addr_d  = hold_addr_q;
    hold_data_d  = hold_data_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q + CW'(mem_push) - CW'(mem_grant);
    rr_last_d    = both ? mem_grant : rr_last_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    if (alu_push) begin
      hold_valid_d = 1'b1;
      hold_addr_d  = alu_addr;
      hold_data_d  = alu_data;
    end else if (alu_grant) begin
      hold_valid_d = 1'b0;
    end
    if (mem_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (mem_grant) rd_ptr_d = rd_ptr_q + PW'(1);
    if (alu_grant) begin
      wr_en_d   = (hold_addr_q != '0);
      wr_addr_d = hold_addr_q;
      wr_data_d = hold_data_q;
    end else if (mem_grant) begin
      wr_en_d   = (fifo_addr_q[rd_ptr_q] != '0);
      wr_addr_d = fifo_addr_q[rd_ptr_q];
      wr_data_d = fifo_data_q[rd_ptr_q];
    end
  end

  // Control and write-port registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      hold_addr_q  <= '0;
      hold_data_q  <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      rr_last_q    <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_addr_q  <= hold_addr_d;
      hold_data_q  <= hold_data_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      rr_last_q    <= rr_last_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  // Load FIFO storage; contents are don't-care while the entry is invalid
  always_ff @(posedge clk) begin
    if (mem_push) begin
      fifo_addr_q[wr_ptr_q] <= mem_addr;
      fifo_data_q[wr_ptr_q] <= mem_data;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = hold_valid_q | fifo_ne | wr_en_q;

`ifdef WB_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        stall;

  // Saturating count of cycles where a producer is back-pressured
  always_comb begin
    stall       = (alu_valid & ~alu_ready) | (mem_valid & ~mem_ready);
    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // Stall counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized + directed bench for regfile_wb_arbiter against a queue-based model.
// Works with or without WB_PERF_EN.
module tb_regfile_wb_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int DEPTH = 4;

  logic          clk = 0;
  logic          rst = 1;
  logic          alu_valid = 0, mem_valid = 0;
  logic          alu_ready, mem_ready;
  logic [AW-1:0] alu_addr = 0, mem_addr = 0;
  logic [DW-1:0] alu_data = 0, mem_data = 0;
  logic          wr_en, busy;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
`ifdef WB_PERF_EN
  logic [31:0]   stall_cnt;
`endif

  regfile_wb_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy)
`ifdef WB_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [AW-1:0] ma_a[$], mq_a[$];
  logic [DW-1:0] ma_d[$], mq_d[$];
  bit            m_rr_mem;
  bit            m_wen;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  int unsigned   m_stall;
  bit            alu_fire, mem_fire;

  function automatic void m_grant(output bit ga, output bit gm);
    bit ha, hm;
    ha = ma_a.size() != 0;
    hm = mq_a.size() != 0;
    ga = 0;
    gm = 0;
    if (ha && hm) begin
      if (m_rr_mem) ga = 1;
      else gm = 1;
    end else if (ha) ga = 1;
    else if (hm) gm = 1;
  endfunction

  always @(posedge clk or posedge rst) begin
    bit ga, gm, ar, mr, both;
    if (rst) begin
      ma_a.delete(); ma_d.delete(); mq_a.delete(); mq_d.delete();
      m_rr_mem = 0; m_wen = 0; m_waddr = 0; m_wdata = 0; m_stall = 0;
      alu_fire = 0; mem_fire = 0;
    end else begin
      m_grant(ga, gm);
      both = ma_a.size() != 0 && mq_a.size() != 0;
      ar = (ma_a.size() == 0) || ga;
      mr = mq_a.size() < DEPTH;
      alu_fire = alu_valid && ar;
      mem_fire = mem_valid && mr;
      if (((alu_valid && !ar) || (mem_valid && !mr)) && m_stall != 32'hFFFF_FFFF)
        m_stall++;
      if (ga) begin
        m_waddr = ma_a.pop_front();
        m_wdata = ma_d.pop_front();
        m_wen = m_waddr != 0;
      end else if (gm) begin
        m_waddr = mq_a.pop_front();
        m_wdata = mq_d.pop_front();
        m_wen = m_waddr != 0;
      end else m_wen = 0;
      if (both) m_rr_mem = gm;
      if (alu_fire) begin ma_a.push_back(alu_addr); ma_d.push_back(alu_data); end
      if (mem_fire) begin mq_a.push_back(mem_addr); mq_d.push_back(mem_data); end
    end
  end

  // compare process: every cycle, mid-period
  always @(negedge clk) begin
    bit ga, gm;
    m_grant(ga, gm);
    chk("alu_ready", alu_ready, (ma_a.size() == 0) || ga);
    chk("mem_ready", mem_ready, mq_a.size() < DEPTH);
    chk("wr_en", wr_en, m_wen);
    chk("wr_addr", wr_addr, m_waddr);
    chk("wr_data", wr_data, m_wdata);
    chk("busy", busy, ma_a.size() != 0 || mq_a.size() != 0 || m_wen);
`ifdef WB_PERF_EN
    chk("stall_cnt", stall_cnt, m_stall);
`endif
  end

  // ---------------- stimulus ----------------
  logic [AW-1:0] sa_a[$], sm_a[$];
  logic [DW-1:0] sa_d[$], sm_d[$];
  logic [AW-1:0] wq[$];
  logic [DW-1:0] wdq[$];
  int pa = 100, pm = 100;
  int saw_mstall = 0;

  task automatic drive();
    if (alu_valid && alu_fire) begin
      void'(sa_a.pop_front()); void'(sa_d.pop_front()); alu_valid = 0;
    end
    if (mem_valid && mem_fire) begin
      void'(sm_a.pop_front()); void'(sm_d.pop_front()); mem_valid = 0;
    end
    if (!alu_valid && sa_a.size() > 0 && $urandom_range(99) < pa) begin
      alu_valid = 1; alu_addr = sa_a[0]; alu_data = sa_d[0];
    end
    if (!mem_valid && sm_a.size() > 0 && $urandom_range(99) < pm) begin
      mem_valid = 1; mem_addr = sm_a[0]; mem_data = sm_d[0];
    end
    if (mem_valid && !mem_ready) saw_mstall++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (wr_en) begin wq.push_back(wr_addr); wdq.push_back(wr_data); end
    drive();
  endtask

  task automatic wait_idle(int lim);
    int n = 0;
    while ((busy || alu_valid || mem_valid || sa_a.size() != 0 || sm_a.size() != 0) && n < lim) begin
      tick();
      n++;
    end
    chk("idle_timeout", n < lim, 1);
  endtask

  initial begin
    logic [AW-1:0] rr_exp [6];
    rr_exp = '{5'd9, 5'd1, 5'd10, 5'd2, 5'd11, 5'd3};
    #12;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_ready", alu_ready, 1);
    chk("rst_mem_ready", mem_ready, 1);
    @(posedge clk); #1; rst = 0;
    tick();

    // single ALU write
    sa_a.push_back(5'd3); sa_d.push_back(32'h11); drive();
    tick(); tick();
    chk("alu_wr_en", wr_en, 1);
    chk("alu_wr_addr", wr_addr, 3);
    chk("alu_wr_data", wr_data, 32'h11);
    tick();
    chk("alu_wr_en_e2", wr_en, 0);
    chk("alu_busy_e2", busy, 0);

    // x0 write is silently consumed
    sa_a.push_back(5'd0); sa_d.push_back(32'hFF); drive();
    tick(); tick();
    chk("x0_wr_en", wr_en, 0);
    chk("x0_wr_data", wr_data, 32'hFF);
    wait_idle(20);

    // load-only stream across the pointer wrap
    wq.delete(); wdq.delete(); saw_mstall = 0;
    for (int i = 0; i < 10; i++) begin
      sm_a.push_back(AW'(i + 1)); sm_d.push_back(32'h100 + i);
    end
    drive();
    wait_idle(40);
    chk("wrap_count", wq.size(), 10);
    for (int i = 0; i < 10 && i < wdq.size(); i++)
      chk("wrap_order", wdq[i], 32'h100 + i);
    chk("wrap_nostall", saw_mstall, 0);

    // round-robin starting from load
    wq.delete(); wdq.delete();
    for (int i = 0; i < 3; i++) begin
      sa_a.push_back(AW'(i + 1)); sa_d.push_back(32'hA0 + i);
      sm_a.push_back(AW'(i + 9)); sm_d.push_back(32'hB0 + i);
    end
    drive();
    wait_idle(40);
    chk("rr_count", wq.size(), 6);
    for (int i = 0; i < 6 && i < wq.size(); i++)
      chk("rr_order", wq[i], rr_exp[i]);

    // both streaming: FIFO fills and back-pressures loads
    saw_mstall = 0;
    for (int i = 0; i < 12; i++) begin
      sa_a.push_back(AW'($urandom_range(31))); sa_d.push_back($urandom);
      sm_a.push_back(AW'($urandom_range(31))); sm_d.push_back($urandom);
    end
    drive();
    wait_idle(80);
    chk("fill_stall_seen", saw_mstall > 0, 1);

    // random traffic
    for (int seg = 0; seg < 20; seg++) begin
      pa = $urandom_range(100);
      pm = $urandom_range(100);
      for (int c = 0; c < 100; c++) begin
        if (sa_a.size() < 3 && $urandom_range(3) != 0) begin
          sa_a.push_back(AW'($urandom_range(31))); sa_d.push_back($urandom);
        end
        if (sm_a.size() < 3 && $urandom_range(3) != 0) begin
          sm_a.push_back(AW'($urandom_range(31))); sm_d.push_back($urandom);
        end
        tick();
      end
    end
    pa = 100; pm = 100;
    wait_idle(200);

    // reset in the middle of heavy traffic
    for (int i = 0; i < 10; i++) begin
      sa_a.push_back(AW'(i + 1)); sa_d.push_back($urandom);
      sm_a.push_back(AW'(i + 12)); sm_d.push_back($urandom);
    end
    drive();
    repeat (7) tick();
    #2;
    rst = 1;
    #1;
    chk("midrst_wr_en", wr_en, 0);
    chk("midrst_busy", busy, 0);
`ifdef WB_PERF_EN
    chk("midrst_stall_cnt", stall_cnt, 0);
`endif
    alu_valid = 0; mem_valid = 0;
    sa_a.delete(); sa_d.delete(); sm_a.delete(); sm_d.delete();
    @(posedge clk); #1; rst = 0;
    wq.delete();
    repeat (5) tick();
    chk("post_rst_no_writes", wq.size(), 0);
    chk("post_rst_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Writeback-side driver for the core's register file write port (wr_en/wr_addr/wr_data). It accepts results from two producers, the single-cycle ALU path and the variable-latency load path, each over a valid/ready handshake. It buffers and arbitrates them, filters writes to x0, and issues at most one registered register-file write per cycle.

Parameters:
AW, 5, register address width (2**AW architectural registers)
DW, 32, register data width
DEPTH, 4, load-path buffer entries; power of 2, >= 2

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  asynchronous, active-high reset
alu_valid  in  1  ALU result valid
alu_ready  out  1  ALU result accepted when valid&ready at posedge
alu_addr  in  AW  ALU destination register
alu_data  in  DW  ALU result
mem_valid  in  1  load result valid
mem_ready  out  1  load result accepted when valid&ready at posedge
mem_addr  in  AW  load destination register
mem_data  in  DW  load data
wr_en  out  1  register file write enable (registered)
wr_addr  out  AW  register file write address (registered)
wr_data  out  DW  register file write data (registered)
busy  out  1  any entry held in either buffer or wr_en high

Behaviour:
- Reset: wr_en=0, wr_addr=0, wr_data=0. ALU hold and load FIFO are empty, rr_last=ALU, busy=0. During reset, alu_ready=1 and mem_ready=1 are combinational but ignored. Reset asserted mid-operation discards all buffered results asynchronously.
- ALU hold: a single entry. alu_ready = ~hold_valid | alu_grant. A push and a pop in the same cycle is allowed.
- Load FIFO: DEPTH entries with circular read/write pointers that wrap at DEPTH.
  - Count width is log2(DEPTH)+1.
  - mem_ready = (count < DEPTH). There is no pass-through when full.
  - A push and a pop in the same cycle leaves count unchanged.
- Arbitration, evaluated combinationally each cycle:
  - If only one source is non-empty, it is granted.
  - If both are non-empty, grant the source not equal to rr_last (round-robin), then set rr_last = granted source.
  - Grant is only possible when a source is non-empty; the write port never stalls.
- Issue: at the posedge ending a grant cycle, the granted entry is popped.
  - wr_addr and wr_data are loaded from the entry.
  - wr_en = (entry addr != 0). x0 writes are consumed silently and wr_addr/wr_data still update.
  - With no grant, wr_en goes to 0 and wr_addr/wr_data hold their values.
- Latency: input handshake at edge E0 leads to wr_en high after E1 (grant in cycle E0..E1). The register file commits at E2. Throughput is 1 write/cycle aggregate.
- Ordering:
  - In-order within each source.
  - No ordering across sources. Upstream guarantees no outstanding WAW to the same register across ALU and load paths.
- busy = hold_valid | (count != 0) | wr_en.

Optional Feature:
WB_PERF_EN:
- Defined: adds output port stall_cnt (32 bits, reset 0). It increments by 1 each cycle where (alu_valid & ~alu_ready) | (mem_valid & ~mem_ready), and saturates at 2**32-1.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset, then an ALU push of addr=3, data=0x11 at E0 -> wr_en=1, wr_addr=3, wr_data=0x11 after E1; wr_en=0 after E2; busy=0 after E2.
- ALU push of addr=0, data=0xFF -> accepted, wr_en stays 0, wr_data=0xFF after E1.
- Hold alu_valid low; push 4 load results back-to-back while the ALU is idle and the FIFO drains -> no stall, writes appear in order on consecutive cycles. Then block draining by granting the ALU: 5 pushes with count reaching 4 -> mem_ready=0 until one pop.
- Both sources continuously valid (ALU addrs 1,2,3; load addrs 9,10,11) -> alternating writes 9,1,10,2,11,3 with round-robin starting from load (rr_last=ALU after reset).
- FIFO pointer wrap: 10 pushes and pops interleaved with DEPTH=4 -> data order preserved across the wrap, count never exceeds 4.
- Assert rst with 3 FIFO entries and the hold full -> wr_en=0 and busy=0 immediately; no stale writes after release. With WB_PERF_EN, stall_cnt=0.
